// File: rtl/sipo_deserializer_8bit.sv
// MSB-first serial-to-parallel receiver with sync-marker word alignment,
// a valid/ready holding register and sticky overrun/framing flags.
//
// state | meaning
// HUNT  | unaligned; waiting for sin_en & sync to mark a word MSB
// SHIFT | locked to word boundaries; cnt = bits of current word received
module sipo_deserializer_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             sync,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err,
    input  logic             clr_flags
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        HUNT  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] sr, sr_n;
    logic [WIDTH-1:0] new_word;
    logic             word_done;
    logic             fe_set;
    logic             ovr_set;

    assign new_word = {sr[WIDTH-2:0], sin};

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        sr_n      = sr;
        word_done = 1'b0;
        fe_set    = 1'b0;
        if (sin_en) begin
            case (state)
                HUNT: begin
                    if (sync) begin
                        sr_n    = new_word;
                        cnt_n   = CW'(1);
                        state_n = SHIFT;
                    end
                end
                SHIFT: begin
                    sr_n = new_word;
                    // sync at cnt==0 is a legal re-mark of the next MSB
                    if (sync && (cnt != '0)) begin
                        fe_set = 1'b1;
                        sr_n   = {{(WIDTH-1){1'b0}}, sin};
                        cnt_n  = CW'(1);
                    end else if (cnt == CW'(WIDTH - 1)) begin
                        word_done = 1'b1;
                        cnt_n     = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    assign ovr_set = word_done && dout_valid && !dout_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HUNT;
            cnt        <= '0;
            sr         <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sr    <= sr_n;
            busy  <= (state_n == SHIFT) && (cnt_n != '0);

            if (word_done) begin
                if (!dout_valid || dout_ready) begin
                    dout       <= new_word;
                    dout_valid <= 1'b1;
                end
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end

            // a set on the same edge as clr_flags wins
            overrun   <= ovr_set || (overrun && !clr_flags);
            frame_err <= fe_set || (frame_err && !clr_flags);
        end
    end

endmodule

// File: tb/tb_sipo_deserializer_8bit.sv
// Self-checking bench: directed vector table, hand-written corner sequences
// and a randomized run compared against a queue-based word-assembly model.
module tb_sipo_deserializer_8bit;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sin = 1'b0;
    logic             sin_en = 1'b0;
    logic             sync = 1'b0;
    logic             dout_ready = 1'b0;
    logic             clr_flags = 1'b0;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             busy;
    logic             overrun;
    logic             frame_err;

    int checks = 0;
    int failures = 0;

    sipo_deserializer_8bit #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .sin_en     (sin_en),
        .sync       (sync),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .clr_flags  (clr_flags)
    );

    always #5 clk = ~clk;

    // reference model: bits of the current word held in a queue
    bit               m_bits[$];
    bit               m_locked;
    logic [WIDTH-1:0] m_dout;
    bit               m_valid;
    bit               m_ovr;
    bit               m_fe;

    task automatic model_reset();
        m_bits.delete();
        m_locked = 0;
        m_dout   = '0;
        m_valid  = 0;
        m_ovr    = 0;
        m_fe     = 0;
    endtask

    task automatic model_step(input bit b, input bit en, input bit sy, input bit rdy, input bit clr);
        bit               done = 0;
        bit               fe_set = 0;
        bit               ovr_set = 0;
        logic [WIDTH-1:0] w = '0;
        if (en) begin
            if (!m_locked) begin
                if (sy) begin
                    m_bits.delete();
                    m_bits.push_back(b);
                    m_locked = 1;
                end
            end else begin
                if (sy && m_bits.size() != 0) begin
                    fe_set = 1;
                    m_bits.delete();
                end
                m_bits.push_back(b);
                if (m_bits.size() == WIDTH) begin
                    foreach (m_bits[i]) w = (w << 1) | WIDTH'(m_bits[i]);
                    done = 1;
                    m_bits.delete();
                end
            end
        end
        if (done) begin
            if (!m_valid || rdy) begin
                m_dout  = w;
                m_valid = 1;
            end else begin
                ovr_set = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        m_ovr = ovr_set || (m_ovr && !clr);
        m_fe  = fe_set || (m_fe && !clr);
    endtask

    function automatic bit model_busy();
        return m_locked && (m_bits.size() != 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // drive one cycle: inputs applied, edge taken, outputs settle 1ns later
    task automatic cyc(input bit b, input bit en, input bit sy, input bit rdy, input bit clr);
        sin        = b;
        sin_en     = en;
        sync       = sy;
        dout_ready = rdy;
        clr_flags  = clr;
        model_step(b, en, sy, rdy, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input bit sync_first, input bit rdy, input bit gaps);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2))
                    cyc(1'($urandom), 1'b0, 1'($urandom), rdy, 1'b0);
            end
            cyc(w[i], 1'b1, sync_first && (i == WIDTH - 1), rdy, 1'b0);
        end
    endtask

    // asynchronous reset asserted between edges; outputs checked before any edge
    task automatic do_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk({tag, "_rst_dout"}, 32'(dout), 32'h0);
        chk({tag, "_rst_valid"}, 32'(dout_valid), 32'h0);
        chk({tag, "_rst_busy"}, 32'(busy), 32'h0);
        chk({tag, "_rst_ovr"}, 32'(overrun), 32'h0);
        chk({tag, "_rst_fe"}, 32'(frame_err), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        bit               b;
        bit               en;
        bit               sy;
        bit               rdy;
        logic [WIDTH-1:0] e_dout;
        bit               e_valid;
        bit               e_busy;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [WIDTH-1:0] single = 8'hB6;
        for (int i = 0; i < WIDTH; i++) begin
            vecs[i].b       = single[WIDTH-1-i];
            vecs[i].en      = 1;
            vecs[i].sy      = (i == 0);
            vecs[i].rdy     = 1;
            vecs[i].e_dout  = (i == WIDTH - 1) ? 8'hB6 : 8'h00;
            vecs[i].e_valid = (i == WIDTH - 1);
            vecs[i].e_busy  = (i != WIDTH - 1);
        end
        vecs[8] = '{b: 0, en: 0, sy: 0, rdy: 1, e_dout: 8'hB6, e_valid: 0, e_busy: 0};

        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_reset("init");

        // single word from the vector table
        foreach (vecs[i]) begin
            cyc(vecs[i].b, vecs[i].en, vecs[i].sy, vecs[i].rdy, 1'b0);
            chk($sformatf("vec%0d_dout", i), 32'(dout), 32'(vecs[i].e_dout));
            chk($sformatf("vec%0d_valid", i), 32'(dout_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            chk($sformatf("vec%0d_flags", i), 32'({overrun, frame_err}), 32'h0);
        end

        // back-to-back, sync only on the first bit
        do_reset("b2b");
        send_word(8'hB6, 1'b1, 1'b1, 1'b0);
        chk("b2b_w0_dout", 32'(dout), 32'hB6);
        chk("b2b_w0_valid", 32'(dout_valid), 32'h1);
        send_word(8'hCC, 1'b0, 1'b1, 1'b0);
        chk("b2b_w1_dout", 32'(dout), 32'hCC);
        chk("b2b_w1_valid", 32'(dout_valid), 32'h1);

        // same words with random sin_en gaps
        do_reset("gap");
        send_word(8'hB6, 1'b1, 1'b1, 1'b1);
        chk("gap_w0_dout", 32'(dout), 32'hB6);
        chk("gap_w0_valid", 32'(dout_valid), 32'h1);
        send_word(8'hCC, 1'b0, 1'b1, 1'b1);
        chk("gap_w1_dout", 32'(dout), 32'hCC);
        chk("gap_w1_valid", 32'(dout_valid), 32'h1);

        // overrun: consumer stalled
        do_reset("ovr");
        send_word(8'hB6, 1'b1, 1'b0, 1'b0);
        chk("ovr_w0_dout", 32'(dout), 32'hB6);
        chk("ovr_w0_flag", 32'(overrun), 32'h0);
        send_word(8'hCC, 1'b0, 1'b0, 1'b0);
        chk("ovr_w1_dout", 32'(dout), 32'hB6);
        chk("ovr_w1_flag", 32'(overrun), 32'h1);
        send_word(8'h5A, 1'b0, 1'b0, 1'b0);
        chk("ovr_w2_dout", 32'(dout), 32'hB6);
        send_word(8'h5A, 1'b0, 1'b1, 1'b0);
        chk("ovr_w3_dout", 32'(dout), 32'h5A);
        chk("ovr_w3_valid", 32'(dout_valid), 32'h1);
        chk("ovr_w3_flag", 32'(overrun), 32'h1);
        chk("ovr_fe", 32'(frame_err), 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr_clr", 32'(overrun), 32'h0);
        chk("ovr_clr_valid", 32'(dout_valid), 32'h1);

        // framing: sync after a 3-bit partial word
        do_reset("frm");
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("frm_busy", 32'(busy), 32'h1);
        chk("frm_fe_pre", 32'(frame_err), 32'h0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("frm_fe_set", 32'(frame_err), 32'h1);
        chk("frm_valid_pre", 32'(dout_valid), 32'h0);
        for (int i = WIDTH - 2; i >= 0; i--) begin
            logic [WIDTH-1:0] cc = 8'hCC;
            cyc(cc[i], 1'b1, 1'b0, 1'b1, 1'b0);
        end
        chk("frm_dout", 32'(dout), 32'hCC);
        chk("frm_valid", 32'(dout_valid), 32'h1);
        chk("frm_fe_hold", 32'(frame_err), 32'h1);

        // set and clear on the same edge: set wins
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("frm_set_wins", 32'(frame_err), 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("frm_clr", 32'(frame_err), 32'h0);

        // reset mid-word after a held word
        do_reset("mid");
        send_word(8'hB6, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("mid_busy", 32'(busy), 32'h1);
        do_reset("mid");
        send_word(8'hF0, 1'b1, 1'b1, 1'b0);
        chk("mid_dout", 32'(dout), 32'hF0);
        chk("mid_valid", 32'(dout_valid), 32'h1);

        // randomized traffic against the reference model
        do_reset("rnd");
        for (int n = 0; n < 3000; n++) begin
            cyc(1'($urandom),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 9) == 0),
                1'($urandom),
                ($urandom_range(0, 19) == 0));
            chk("rnd_dout", 32'(dout), 32'(m_dout));
            chk("rnd_valid", 32'(dout_valid), 32'(m_valid));
            chk("rnd_busy", 32'(busy), 32'(model_busy()));
            chk("rnd_ovr", 32'(overrun), 32'(m_ovr));
            chk("rnd_fe", 32'(frame_err), 32'(m_fe));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
